// File: rtl/instruction_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cache_pkg
// Description : Shared geometry and state encodings for the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_cache_pkg;

    localparam int ICACHE_INDEX_WIDTH = 6;
    localparam int ICACHE_ADDR_WIDTH  = 18;
    localparam int ICACHE_TAG_WIDTH   = ICACHE_ADDR_WIDTH - 2 - ICACHE_INDEX_WIDTH;

    typedef enum logic [0:0] {
        ICACHE_IDLE = 1'b0,
        ICACHE_MISS = 1'b1
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_store.sv
`default_nettype none
// ============================================================================
// Module      : icache_store
// Description : Direct-mapped line storage: resettable valid bits plus tag and
//               data arrays, combinational lookup and synchronous fill port.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_store
    import instruction_cache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int TAG_WIDTH   = ICACHE_TAG_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] i_rd_index,
    input  logic [TAG_WIDTH-1:0]   i_rd_tag,
    output logic                   o_rd_hit,
    output logic [31:0]            o_rd_data,
    input  logic                   i_wr_en,
    input  logic [INDEX_WIDTH-1:0] i_wr_index,
    input  logic [TAG_WIDTH-1:0]   i_wr_tag,
    input  logic [31:0]            i_wr_data
);

    localparam int c_LINES = 1 << INDEX_WIDTH;

    logic [c_LINES-1:0]   r_valid;
    logic [TAG_WIDTH-1:0] r_tag  [c_LINES];
    logic [31:0]          r_data [c_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_hit  = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
    assign o_rd_data = r_data[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cache
// Description : Direct-mapped one-word-line instruction cache with a single
//               outstanding memory read and flush/stall support.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        dec_en,
    input  logic [31:0] dec_addr,
    output logic        dec_rdy,
    output logic [31:0] dec_data,
    output logic        mc_en,
    output logic [31:0] mc_addr,
    input  logic        mc_rdy,
    input  logic [31:0] mc_data
);

    localparam int c_TAG_WIDTH = ADDR_WIDTH - 2 - INDEX_WIDTH;

    icache_state_t r_state;
    icache_state_t w_state_next;
    logic          r_dec_rdy;
    logic          w_dec_rdy_next;
    logic [31:0]   r_dec_data;
    logic [31:0]   w_dec_data_next;
    logic          r_mc_en;
    logic          w_mc_en_next;
    logic [31:0]   r_mc_addr;
    logic [31:0]   w_mc_addr_next;
    logic          w_fill;
    logic          w_hit;
    logic [31:0]   w_line_data;

    logic [INDEX_WIDTH-1:0] w_req_index;
    logic [c_TAG_WIDTH-1:0] w_req_tag;
    logic                   w_unused_addr_bits;

    assign w_req_index        = dec_addr[INDEX_WIDTH+1:2];
    assign w_req_tag          = dec_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign w_unused_addr_bits = ^{dec_addr[31:ADDR_WIDTH], dec_addr[1:0]};

    // The outstanding read address doubles as the latched fill index/tag.
    icache_store #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (c_TAG_WIDTH)
    ) u_store (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_rd_index (w_req_index),
        .i_rd_tag   (w_req_tag),
        .o_rd_hit   (w_hit),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_fill && rdy_in && !rst_in),
        .i_wr_index (r_mc_addr[INDEX_WIDTH+1:2]),
        .i_wr_tag   (r_mc_addr[ADDR_WIDTH-1:INDEX_WIDTH+2]),
        .i_wr_data  (mc_data)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ICACHE_IDLE;
            r_dec_rdy  <= 1'b0;
            r_dec_data <= '0;
            r_mc_en    <= 1'b0;
            r_mc_addr  <= '0;
        end else if (rdy_in) begin
            r_state    <= w_state_next;
            r_dec_rdy  <= w_dec_rdy_next;
            r_dec_data <= w_dec_data_next;
            r_mc_en    <= w_mc_en_next;
            r_mc_addr  <= w_mc_addr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_dec_rdy_next  = 1'b0;
        w_dec_data_next = r_dec_data;
        w_mc_en_next    = r_mc_en;
        w_mc_addr_next  = r_mc_addr;
        w_fill          = 1'b0;
        case (r_state)
            ICACHE_IDLE: begin
                // A request seen while the previous response is on the bus is the bubble.
                if (!flush && dec_en && !r_dec_rdy) begin
                    if (w_hit) begin
                        w_dec_rdy_next  = 1'b1;
                        w_dec_data_next = w_line_data;
                    end else begin
                        w_mc_en_next   = 1'b1;
                        w_mc_addr_next = {dec_addr[31:2], 2'b00};
                        w_state_next   = ICACHE_MISS;
                    end
                end
            end
            ICACHE_MISS: begin
                if (mc_rdy) begin
                    w_fill       = 1'b1;
                    w_mc_en_next = 1'b0;
                    w_state_next = ICACHE_IDLE;
                    if (!flush) begin
                        w_dec_rdy_next  = 1'b1;
                        w_dec_data_next = mc_data;
                    end
                end else if (flush) begin
                    w_mc_en_next = 1'b0;
                    w_state_next = ICACHE_IDLE;
                end
            end
            default: begin
                w_state_next = ICACHE_IDLE;
                w_mc_en_next = 1'b0;
            end
        endcase
    end

    assign dec_rdy  = r_dec_rdy;
    assign dec_data = r_dec_data;
    assign mc_en    = r_mc_en;
    assign mc_addr  = r_mc_addr;

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_cache
// Description : Directed and randomized bench for instruction_cache against a
//               line-contents reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_cache;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush, dec_en, mc_rdy;
    logic [31:0] dec_addr, mc_data;
    logic        dec_rdy, mc_en;
    logic [31:0] dec_data, mc_addr;

    always #5 clk_in = ~clk_in;

    instruction_cache dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .dec_en   (dec_en),
        .dec_addr (dec_addr),
        .dec_rdy  (dec_rdy),
        .dec_data (dec_data),
        .mc_en    (mc_en),
        .mc_addr  (mc_addr),
        .mc_rdy   (mc_rdy),
        .mc_data  (mc_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: each line remembers which word address (low 16 bits) it holds.
    bit          line_v [64];
    logic [15:0] line_w [64];
    logic [31:0] line_d [64];
    bit          m_dec_rdy;
    logic [31:0] m_dec_data;
    bit          m_mc_en;
    logic [31:0] m_mc_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic model_step();
        logic [15:0] w;
        bit          was_rdy;
        if (rst_in) begin
            foreach (line_v[i]) line_v[i] = 1'b0;
            m_dec_rdy = 0; m_dec_data = '0; m_mc_en = 0; m_mc_addr = '0;
        end else if (rdy_in) begin
            was_rdy   = m_dec_rdy;
            m_dec_rdy = 0;
            if (m_mc_en) begin
                if (mc_rdy) begin
                    w = m_mc_addr[17:2];
                    line_v[w % 64] = 1'b1;
                    line_w[w % 64] = w;
                    line_d[w % 64] = mc_data;
                    m_mc_en = 0;
                    if (!flush) begin m_dec_rdy = 1; m_dec_data = mc_data; end
                end else if (flush) begin
                    m_mc_en = 0;
                end
            end else if (!flush && dec_en && !was_rdy) begin
                w = dec_addr[17:2];
                if (line_v[w % 64] && line_w[w % 64] == w) begin
                    m_dec_rdy = 1; m_dec_data = line_d[w % 64];
                end else begin
                    m_mc_en = 1; m_mc_addr = {dec_addr[31:2], 2'b00};
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check("dec_rdy", {31'b0, dec_rdy}, {31'b0, m_dec_rdy});
        check("mc_en", {31'b0, mc_en}, {31'b0, m_mc_en});
        if (m_dec_rdy) check("dec_data", dec_data, m_dec_data);
        if (m_mc_en) check("mc_addr", mc_addr, m_mc_addr);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk_in);
        compare_outputs();
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; flush = 0; dec_en = 0; mc_rdy = 0;
        dec_addr = '0; mc_data = '0;
    endtask

    task automatic req(input logic [31:0] a);
        dec_en = 1; dec_addr = a;
    endtask

    task automatic fill(input logic [31:0] d);
        mc_rdy = 1; mc_data = d;
    endtask

    bit          d_active;
    logic [31:0] d_addr;
    int          mem_cnt;
    bit          sampled;

    initial begin
        idle(); rst_in = 1;
        tick();
        check("rst_dec_rdy", {31'b0, dec_rdy}, 32'd0);
        check("rst_dec_data", dec_data, 32'd0);
        check("rst_mc_en", {31'b0, mc_en}, 32'd0);
        check("rst_mc_addr", mc_addr, 32'd0);
        idle();

        // Cold miss then fill.
        req(32'h10); tick();
        check("cold_mc_en", {31'b0, mc_en}, 32'd1);
        check("cold_mc_addr", mc_addr, 32'h10);
        tick();
        fill(32'h00500093); tick();
        check("cold_dec_rdy", {31'b0, dec_rdy}, 32'd1);
        check("cold_dec_data", dec_data, 32'h00500093);
        check("cold_mc_en_drop", {31'b0, mc_en}, 32'd0);
        idle(); tick();
        check("pulse_one_cycle", {31'b0, dec_rdy}, 32'd0);

        // Hit.
        req(32'h10); tick();
        check("hit_dec_rdy", {31'b0, dec_rdy}, 32'd1);
        check("hit_dec_data", dec_data, 32'h00500093);
        check("hit_no_mc_en", {31'b0, mc_en}, 32'd0);
        tick();
        check("bubble", {31'b0, dec_rdy}, 32'd0);
        idle(); tick();

        // Conflict on the same index.
        req(32'h110); tick();
        check("conf_mc_addr", mc_addr, 32'h110);
        fill(32'h11111111); tick();
        check("conf_dec_data", dec_data, 32'h11111111);
        idle(); tick();
        req(32'h10); tick();
        check("conf_remiss", {31'b0, mc_en}, 32'd1);
        fill(32'h00500093); tick();
        idle(); tick();

        // Flush two cycles into a miss.
        req(32'h20); tick(); tick();
        flush = 1; tick();
        check("flush_mc_en", {31'b0, mc_en}, 32'd0);
        check("flush_dec_rdy", {31'b0, dec_rdy}, 32'd0);
        idle(); tick();
        check("flush_no_resp", {31'b0, dec_rdy}, 32'd0);
        req(32'h20); tick();
        check("refetch_miss", {31'b0, mc_en}, 32'd1);
        flush = 1; fill(32'hABCD0001); tick();
        check("flush_fill_dec_rdy", {31'b0, dec_rdy}, 32'd0);
        check("flush_fill_mc_en", {31'b0, mc_en}, 32'd0);
        idle(); tick();
        req(32'h20); tick();
        check("flush_fill_hit", {31'b0, dec_rdy}, 32'd1);
        check("flush_fill_data", dec_data, 32'hABCD0001);
        idle(); tick();

        // Stall during a miss, then during a hit response.
        req(32'h40); tick();
        rdy_in = 0; fill(32'h40404040);
        for (int i = 0; i < 5; i++) tick();
        check("stall_mc_en", {31'b0, mc_en}, 32'd1);
        check("stall_no_resp", {31'b0, dec_rdy}, 32'd0);
        rdy_in = 1; tick();
        check("stall_resp", dec_data, 32'h40404040);
        idle(); tick();
        req(32'h40); tick();
        rdy_in = 0; dec_en = 0;
        for (int i = 0; i < 5; i++) tick();
        check("stall_hold_rdy", {31'b0, dec_rdy}, 32'd1);
        rdy_in = 1; tick();
        check("stall_release", {31'b0, dec_rdy}, 32'd0);

        // Reset during a miss.
        req(32'h80); tick();
        rst_in = 1; tick();
        check("rst_miss_mc_en", {31'b0, mc_en}, 32'd0);
        check("rst_miss_dec_rdy", {31'b0, dec_rdy}, 32'd0);
        rst_in = 0; req(32'h10); tick();
        check("rst_invalidates", {31'b0, mc_en}, 32'd1);
        fill(32'h00500093); tick();
        idle(); tick();

        // Randomized traffic with a well-behaved decoder and memory.
        d_active = 0; d_addr = '0; mem_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            sampled = rst_in || rdy_in;
            if (sampled && (rst_in || flush || m_dec_rdy)) d_active = 0;
            rst_in = ($urandom_range(0, 299) == 0);
            rdy_in = ($urandom_range(0, 7) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            if (!d_active && $urandom_range(0, 1) == 1) begin
                d_active     = 1;
                d_addr       = $urandom;
                d_addr[7:2]  = 6'($urandom_range(0, 3) * 5);
                d_addr[17:8] = 10'($urandom_range(0, 2));
            end
            dec_en   = d_active;
            dec_addr = d_active ? d_addr : $urandom;
            mc_rdy   = 0;
            mc_data  = $urandom;
            if (m_mc_en && rdy_in) begin
                if (mem_cnt == 0) begin
                    mc_rdy  = 1;
                    mc_data = mem_word(m_mc_addr);
                    mem_cnt = $urandom_range(0, 4);
                end else begin
                    mem_cnt--;
                end
            end
            tick();
        end

        idle(); tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
